// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit clocked frame, ACK check.
// Optional watchdog on the device-clocked phase is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // One counter times the inhibit period and, when enabled, the watchdog, so it spans both.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(FILTER_LEN + 1);

   localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);
`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      XMIT,
      WAIT_IDLE,
      DONE
   } state_t;

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_filt;
   logic          clk_fall;
   logic [FW-1:0] filt_cnt;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          parity;

   // Pins idle high through the pull-ups, so the synchronizers and filter reset to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_filt  <= 1'b1;
         filt_cnt  <= '0;
         clk_fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the previous-cycle values,
         // which is what makes the two-stage synchronizer two stages deep.
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_fall  <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILTER_LAST) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
            clk_fall <= ~clk_sync[1];
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         parity      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         // NOTE: done defaults low every cycle, so any branch that raises it yields a single-cycle pulse.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  shreg      <= tx_data;
                  parity     <= ~^tx_data;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  cnt        <= '0;
                  state      <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (cnt == INHIBIT_LAST) begin
                  ps2_data_oe <= 1'b1;
                  state       <= REQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            REQ: begin
               ps2_clk_oe <= 1'b0;
               cnt        <= '0;
               bit_cnt    <= '0;
               state      <= XMIT;
            end

            XMIT: begin
               // The device clocks the frame; the start bit stays on the wire until its first fall.
               if (clk_fall) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     ps2_data_oe <= ~shreg[0];
                     shreg       <= {1'b0, shreg[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                     ps2_data_oe <= ~parity;
                  end else if (bit_cnt == 4'd9) begin
                     ps2_data_oe <= 1'b0;
                  end else begin
                     err   <= data_sync[1];
                     state <= WAIT_IDLE;
                  end
               end
`ifdef PS2_TX_TIMEOUT_EN
               // A silent or stalled device aborts the frame; this overrides any fall handled above.
               cnt <= cnt + 1'b1;
               if (cnt == TIMEOUT_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  err         <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end
`endif
            end

            WAIT_IDLE: begin
               if (clk_filt && data_sync[1]) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule
